// File: rtl/conv_wb_desc_gen.sv
// Write-back descriptor generator: walks OC groups (outer) and pixel blocks (inner) once per
// layer and pushes one {addr, mask, last} descriptor per PPU output vector into the desc FIFO.
`ifndef RTM_DEPTH
`define RTM_DEPTH 1024
`endif

module conv_wb_desc_gen #(
    parameter int  RTM_DEPTH = `RTM_DEPTH,
    parameter int  CNT_W     = 16,
    localparam int AW        = $clog2(RTM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_pulse,
    input  logic [AW-1:0]    cfg_base_addr,
    input  logic [AW-1:0]    cfg_oc_stride,
    input  logic [CNT_W-1:0] cfg_n_oc_grp,
    input  logic [CNT_W-1:0] cfg_n_pix_blk,
    input  logic [CNT_W-1:0] cfg_n_pix_vld,
    output logic             busy,
    output logic             done_pulse,
    output logic             desc_fifo_wr_en,
    output logic [AW-1:0]    desc_fifo_din_addr,
    output logic             desc_fifo_din_mask,
    output logic             desc_fifo_din_last,
    input  logic             desc_fifo_full
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    ZERO_AW  = {AW{1'b0}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] oc_q, oc_d, pb_q, pb_d;
    logic [AW-1:0]    row_q, row_d, stride_q, stride_d;
    logic [CNT_W-1:0] n_oc_q, n_oc_d, n_pix_q, n_pix_d, n_vld_q, n_vld_d;
    logic             wr_en_q, wr_en_d, mask_q, mask_d, last_q, last_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [AW-1:0]    addr_q, addr_d;

    logic             launch_s, nonzero_s, push_s, last_s, pb_end_s;
    logic [CNT_W-1:0] cur_oc_s, cur_pb_s, cur_n_oc_s, cur_n_pix_s, cur_n_vld_s;
    logic [AW-1:0]    cur_row_s, cur_stride_s;

    assign launch_s = (state_q == S_IDLE) && start_pulse;

    // Working loop context: the start cycle pushes straight from cfg so wr_en follows start by one cycle
    always_comb begin
        if (launch_s) begin
            cur_oc_s     = ZERO_CNT;
            cur_pb_s     = ZERO_CNT;
            cur_row_s    = cfg_base_addr;
            cur_stride_s = cfg_oc_stride;
            cur_n_oc_s   = cfg_n_oc_grp;
            cur_n_pix_s  = cfg_n_pix_blk;
            cur_n_vld_s  = cfg_n_pix_vld;
        end else begin
            cur_oc_s     = oc_q;
            cur_pb_s     = pb_q;
            cur_row_s    = row_q;
            cur_stride_s = stride_q;
            cur_n_oc_s   = n_oc_q;
            cur_n_pix_s  = n_pix_q;
            cur_n_vld_s  = n_vld_q;
        end
    end

    assign nonzero_s = (cur_n_oc_s != ZERO_CNT) && (cur_n_pix_s != ZERO_CNT);
    assign push_s    = ((state_q == S_GEN) || (launch_s && nonzero_s)) && !desc_fifo_full;
    assign pb_end_s  = (cur_pb_s == (cur_n_pix_s - ONE_CNT));
    assign last_s    = (cur_oc_s == (cur_n_oc_s - ONE_CNT)) && pb_end_s;

    // Next-state, loop advance and registered descriptor outputs
    always_comb begin
        state_d  = state_q;
        oc_d     = oc_q;
        pb_d     = pb_q;
        row_d    = row_q;
        stride_d = stride_q;
        n_oc_d   = n_oc_q;
        n_pix_d  = n_pix_q;
        n_vld_d  = n_vld_q;
        wr_en_d  = 1'b0;
        addr_d   = addr_q;
        mask_d   = mask_q;
        last_d   = last_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_pulse) begin
                    stride_d = cfg_oc_stride;
                    n_oc_d   = cfg_n_oc_grp;
                    n_pix_d  = cfg_n_pix_blk;
                    n_vld_d  = cfg_n_pix_vld;
                    oc_d     = ZERO_CNT;
                    pb_d     = ZERO_CNT;
                    row_d    = cfg_base_addr;
                    addr_d   = cfg_base_addr;
                    if (nonzero_s) begin
                        state_d = S_GEN;
                    end else begin
                        state_d = S_FIN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GEN: begin
                state_d = S_GEN;
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push_s) begin
            wr_en_d = 1'b1;
            addr_d  = cur_row_s + AW'(cur_pb_s);
            mask_d  = (cur_pb_s >= cur_n_vld_s);
            last_d  = last_s;
            if (last_s) begin
                state_d = S_FIN;
            end else begin
                state_d = S_GEN;
            end
            if (pb_end_s) begin
                pb_d  = ZERO_CNT;
                oc_d  = cur_oc_s + ONE_CNT;
                row_d = cur_row_s + cur_stride_s;
            end else begin
                pb_d  = cur_pb_s + ONE_CNT;
            end
        end else begin
            wr_en_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, loop counters, latched config and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            oc_q     <= ZERO_CNT;
            pb_q     <= ZERO_CNT;
            row_q    <= ZERO_AW;
            stride_q <= ZERO_AW;
            n_oc_q   <= ZERO_CNT;
            n_pix_q  <= ZERO_CNT;
            n_vld_q  <= ZERO_CNT;
            wr_en_q  <= 1'b0;
            addr_q   <= ZERO_AW;
            mask_q   <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            oc_q     <= oc_d;
            pb_q     <= pb_d;
            row_q    <= row_d;
            stride_q <= stride_d;
            n_oc_q   <= n_oc_d;
            n_pix_q  <= n_pix_d;
            n_vld_q  <= n_vld_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy               = busy_q;
    assign done_pulse         = done_q;
    assign desc_fifo_wr_en    = wr_en_q;
    assign desc_fifo_din_addr = addr_q;
    assign desc_fifo_din_mask = mask_q;
    assign desc_fifo_din_last = last_q;

endmodule

// File: tb/tb_conv_wb_desc_gen.sv
// Directed bench for conv_wb_desc_gen: a monitor records every push and done pulse with its
// cycle stamp; each test task compares against hand-computed descriptor sequences.
module tb_conv_wb_desc_gen;

    localparam int D  = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_pulse = 1'b0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [AW-1:0] cfg_oc_stride = '0;
    logic [15:0]   cfg_n_oc_grp = '0;
    logic [15:0]   cfg_n_pix_blk = '0;
    logic [15:0]   cfg_n_pix_vld = '0;
    logic          busy, done_pulse, desc_fifo_wr_en;
    logic [AW-1:0] desc_fifo_din_addr;
    logic          desc_fifo_din_mask, desc_fifo_din_last;
    logic          desc_fifo_full = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    conv_wb_desc_gen #(.RTM_DEPTH(D), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start_pulse(start_pulse),
        .cfg_base_addr(cfg_base_addr), .cfg_oc_stride(cfg_oc_stride),
        .cfg_n_oc_grp(cfg_n_oc_grp), .cfg_n_pix_blk(cfg_n_pix_blk), .cfg_n_pix_vld(cfg_n_pix_vld),
        .busy(busy), .done_pulse(done_pulse), .desc_fifo_wr_en(desc_fifo_wr_en),
        .desc_fifo_din_addr(desc_fifo_din_addr), .desc_fifo_din_mask(desc_fifo_din_mask),
        .desc_fifo_din_last(desc_fifo_din_last), .desc_fifo_full(desc_fifo_full)
    );

    always #5 clk = ~clk;

    int            cyc = 0;
    logic          full_smp = 1'b0;
    int            viol = 0;
    logic [AW-1:0] q_addr[$];
    logic          q_mask[$];
    logic          q_last[$];
    int            q_cyc[$];
    int            q_done[$];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        full_smp <= desc_fifo_full;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (desc_fifo_wr_en) begin
                q_addr.push_back(desc_fifo_din_addr);
                q_mask.push_back(desc_fifo_din_mask);
                q_last.push_back(desc_fifo_din_last);
                q_cyc.push_back(cyc);
                if (full_smp) viol <= viol + 1;
            end
            if (done_pulse) q_done.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input int base, input int stride, input int noc, input int npix, input int nvld);
        start_pulse   = 1'b1;
        cfg_base_addr = AW'(base);
        cfg_oc_stride = AW'(stride);
        cfg_n_oc_grp  = 16'(noc);
        cfg_n_pix_blk = 16'(npix);
        cfg_n_pix_vld = 16'(nvld);
        tick();
        start_pulse   = 1'b0;
        cfg_base_addr = 6'd33;
        cfg_n_oc_grp  = 16'd7;
    endtask

    task automatic wait_done(input int db, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (q_done.size() > db) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_vec++; if (desc_fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", desc_fifo_wr_en); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done_pulse !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_pulse); end
        n_vec++; if (desc_fifo_din_addr !== 6'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", desc_fifo_din_addr); end
        n_vec++; if ({desc_fifo_din_mask, desc_fifo_din_last} !== 2'b00) begin n_err++; $display("FAIL reset_mask_last got %b want 00", {desc_fifo_din_mask, desc_fifo_din_last}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int exp_a[6] = '{10, 11, 12, 14, 15, 16};
        int p0 = q_addr.size();
        int db = q_done.size();
        int s  = cyc;
        bit ok;
        drive_start(10, 4, 2, 3, 3);
        wait_done(db, 50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL basic_timeout got no done want done"); end
        n_vec++; if (q_addr.size() - p0 != 6) begin n_err++; $display("FAIL basic_count got %0d want 6", q_addr.size() - p0); end
        for (int i = 0; i < 6; i++) begin
            if (p0 + i < q_addr.size()) begin
                n_vec++; if (q_addr[p0+i] !== AW'(exp_a[i])) begin n_err++; $display("FAIL basic_addr[%0d] got %0d want %0d", i, q_addr[p0+i], exp_a[i]); end
                n_vec++; if (q_mask[p0+i] !== 1'b0) begin n_err++; $display("FAIL basic_mask[%0d] got %b want 0", i, q_mask[p0+i]); end
                n_vec++; if (q_last[p0+i] !== (i == 5)) begin n_err++; $display("FAIL basic_last[%0d] got %b want %b", i, q_last[p0+i], (i == 5)); end
                n_vec++; if (q_cyc[p0+i] != s + 1 + i) begin n_err++; $display("FAIL basic_cycle[%0d] got %0d want %0d", i, q_cyc[p0+i], s + 1 + i); end
            end
        end
        if (ok) begin
            n_vec++; if (q_done[db] != s + 7) begin n_err++; $display("FAIL basic_done_cycle got %0d want %0d", q_done[db], s + 7); end
        end
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got %b want 0", busy); end
    endtask

    task automatic test_mask_wrap(input int base, input int nvld, input int m0, input int m1, input int m2, input int m3,
                                  input int a0, input int a1, input int a2, input int a3);
        int exp_a[4] = '{a0, a1, a2, a3};
        int exp_m[4] = '{m0, m1, m2, m3};
        int p0 = q_addr.size();
        int db = q_done.size();
        bit ok;
        drive_start(base, 0, 1, 4, nvld);
        wait_done(db, 50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL mw_timeout got no done want done"); end
        n_vec++; if (q_addr.size() - p0 != 4) begin n_err++; $display("FAIL mw_count got %0d want 4", q_addr.size() - p0); end
        for (int i = 0; i < 4; i++) begin
            if (p0 + i < q_addr.size()) begin
                n_vec++; if (q_addr[p0+i] !== AW'(exp_a[i])) begin n_err++; $display("FAIL mw_addr[%0d] got %0d want %0d", i, q_addr[p0+i], exp_a[i]); end
                n_vec++; if (q_mask[p0+i] !== 1'(exp_m[i])) begin n_err++; $display("FAIL mw_mask[%0d] got %b want %0d", i, q_mask[p0+i], exp_m[i]); end
                n_vec++; if (q_last[p0+i] !== (i == 3)) begin n_err++; $display("FAIL mw_last[%0d] got %b want %b", i, q_last[p0+i], (i == 3)); end
            end
        end
        tick();
    endtask

    task automatic test_stall();
        int exp_a[12] = '{5, 6, 7, 8, 13, 14, 15, 16, 21, 22, 23, 24};
        int p0 = q_addr.size();
        int db = q_done.size();
        int v0 = viol;
        int s  = cyc;
        int nlast = 0;
        bit ok = 1'b0;
        drive_start(5, 8, 3, 4, 3);
        for (int k = 1; k < 300; k++) begin
            if (q_done.size() > db) begin
                ok = 1'b1;
                break;
            end
            if (k <= 5) desc_fifo_full = 1'b1;
            else        desc_fifo_full = 1'($urandom_range(0, 1));
            tick();
        end
        desc_fifo_full = 1'b0;
        n_vec++; if (!ok) begin n_err++; $display("FAIL stall_timeout got no done want done"); end
        n_vec++; if (q_addr.size() - p0 != 12) begin n_err++; $display("FAIL stall_count got %0d want 12", q_addr.size() - p0); end
        for (int i = 0; i < 12; i++) begin
            if (p0 + i < q_addr.size()) begin
                n_vec++; if (q_addr[p0+i] !== AW'(exp_a[i])) begin n_err++; $display("FAIL stall_addr[%0d] got %0d want %0d", i, q_addr[p0+i], exp_a[i]); end
                n_vec++; if (q_mask[p0+i] !== ((i % 4) == 3)) begin n_err++; $display("FAIL stall_mask[%0d] got %b want %b", i, q_mask[p0+i], ((i % 4) == 3)); end
                if (q_last[p0+i]) nlast++;
            end
        end
        n_vec++; if (nlast != 1) begin n_err++; $display("FAIL stall_last_count got %0d want 1", nlast); end
        n_vec++; if (viol - v0 != 0) begin n_err++; $display("FAIL stall_push_while_full got %0d want 0", viol - v0); end
        if (ok) begin
            n_vec++; if (q_done[db] < s + 18) begin n_err++; $display("FAIL stall_done_cycle got %0d want >= %0d", q_done[db], s + 18); end
        end
        tick();
    endtask

    task automatic test_zero(input int noc, input int npix);
        int p0 = q_addr.size();
        int db = q_done.size();
        int s  = cyc;
        bit ok;
        drive_start(20, 1, noc, npix, 3);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_busy got %b want 1", busy); end
        wait_done(db, 20, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL zero_timeout got no done want done"); end
        if (ok) begin
            n_vec++; if (q_done[db] != s + 2) begin n_err++; $display("FAIL zero_done_cycle got %0d want %0d", q_done[db], s + 2); end
        end
        repeat (3) tick();
        n_vec++; if (q_addr.size() != p0) begin n_err++; $display("FAIL zero_pushes got %0d want 0", q_addr.size() - p0); end
    endtask

    task automatic test_back_to_back();
        int exp_a[6] = '{10, 11, 12, 14, 15, 16};
        int p0 = q_addr.size();
        int db = q_done.size();
        int s  = cyc;
        drive_start(10, 4, 2, 3, 3);
        tick();
        drive_start(40, 1, 1, 1, 1);
        repeat (3) tick();
        drive_start(50, 1, 1, 1, 1);
        repeat (8) tick();
        n_vec++; if (q_addr.size() - p0 != 6) begin n_err++; $display("FAIL b2b_count got %0d want 6", q_addr.size() - p0); end
        for (int i = 0; i < 6; i++) begin
            if (p0 + i < q_addr.size()) begin
                n_vec++; if (q_addr[p0+i] !== AW'(exp_a[i])) begin n_err++; $display("FAIL b2b_addr[%0d] got %0d want %0d", i, q_addr[p0+i], exp_a[i]); end
            end
        end
        n_vec++; if (q_done.size() - db != 1) begin n_err++; $display("FAIL b2b_done_count got %0d want 1", q_done.size() - db); end
        if (q_done.size() > db) begin
            n_vec++; if (q_done[db] != s + 7) begin n_err++; $display("FAIL b2b_done_cycle got %0d want %0d", q_done[db], s + 7); end
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int exp_a[6] = '{10, 11, 12, 14, 15, 16};
        int db;
        int p0;
        bit ok;
        drive_start(10, 4, 2, 3, 3);
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (desc_fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL rstmid_wr_en got %b want 0", desc_fifo_wr_en); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_vec++; if (desc_fifo_din_addr !== 6'd0) begin n_err++; $display("FAIL rstmid_addr got %0d want 0", desc_fifo_din_addr); end
        repeat (2) tick();
        rst = 1'b0;
        db = q_done.size();
        repeat (5) tick();
        n_vec++; if (q_done.size() != db) begin n_err++; $display("FAIL rstmid_done got %0d want 0", q_done.size() - db); end
        p0 = q_addr.size();
        drive_start(10, 4, 2, 3, 3);
        wait_done(db, 50, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rstmid_timeout got no done want done"); end
        n_vec++; if (q_addr.size() - p0 != 6) begin n_err++; $display("FAIL rstmid_count got %0d want 6", q_addr.size() - p0); end
        for (int i = 0; i < 6; i++) begin
            if (p0 + i < q_addr.size()) begin
                n_vec++; if (q_addr[p0+i] !== AW'(exp_a[i])) begin n_err++; $display("FAIL rstmid_addr[%0d] got %0d want %0d", i, q_addr[p0+i], exp_a[i]); end
                n_vec++; if (q_last[p0+i] !== (i == 5)) begin n_err++; $display("FAIL rstmid_last[%0d] got %b want %b", i, q_last[p0+i], (i == 5)); end
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask_wrap(20, 2, 0, 0, 1, 1, 20, 21, 22, 23);
        test_mask_wrap(D - 2, 4, 0, 0, 0, 0, D - 2, D - 1, 0, 1);
        test_stall();
        test_zero(0, 3);
        test_zero(2, 0);
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
